// File: rtl/alu_pkgs.sv
// Shared types and helpers for the EXU arithmetic units.
//   muldiv_op_t    : RV32M operation select (3 bits)
//   muldiv_state_t : iterative mul/div sequencer states
//   is_div / is_signed_a / is_signed_b : op decode helpers
package alu_pkgs;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  function automatic logic is_div(input muldiv_op_t op);
    return op[2];
  endfunction

  // MUL is treated as signed; its low half is identical either way.
  function automatic logic is_signed_a(input muldiv_op_t op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic is_signed_b(input muldiv_op_t op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the iterative mul/div datapath.
//   div_i  : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i  : 2*WIDTH partial register
//            multiply: {partial product, remaining multiplier bits}
//            divide  : {partial remainder, remaining dividend / quotient bits}
//   opnd_i : multiplicand (multiply) or divisor (divide) magnitude
//   acc_o  : partial register after this iteration
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and the MSB of the WIDTH+1-bit difference is the
  // borrow (set exactly when the trial subtraction goes negative).
  always_comb begin
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd_i};
    if (!div_i) begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    end else begin
      acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/iter_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring
// divider on operand magnitudes, one result bit per cycle, sign fix-up at end.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : request handshake (op, A, B sampled on accept)
//   op                   : muldiv_op_t operation select
//   A, B                 : rs1 / dividend, rs2 / divisor
//   out_valid / out_ready: result handshake, Result held until consumed
//   Result               : final result
//   busy                 : unit not idle
// Optional: define MULDIV_FAST_PATH_EN to finish divide-by-zero, signed
// overflow and zero-operand multiplies in one cycle (IDLE -> DONE).
module iter_muldiv
  import alu_pkgs::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             busy
);

  muldiv_state_t          state_q, state_d;
  muldiv_op_t             op_q, op_d;
  logic                   neg_q, neg_d;
  logic                   dz_q, dz_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]       dvs_q, dvs_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       res_q, res_d;

  logic                   sign_a, sign_b, neg_in;
  logic [WIDTH-1:0]       mag_a, mag_b;
  logic [2*WIDTH-1:0]     acc_nxt, prod_neg;
  logic [WIDTH-1:0]       quot, rem, fix_res;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i  (is_div(op_q)),
    .acc_i  (acc_q),
    .opnd_i (dvs_q),
    .acc_o  (acc_nxt)
  );

  always_comb begin
    sign_a = is_signed_a(op) & A[WIDTH-1];
    sign_b = is_signed_b(op) & B[WIDTH-1];
    mag_a  = sign_a ? -A : A;
    mag_b  = sign_b ? -B : B;
    neg_in = ((op == MD_REM) || (op == MD_REMU)) ? sign_a : (sign_a ^ sign_b);
  end

  // Multiply high halves need the negate across the full 2*WIDTH product;
  // quotient and remainder are negated independently.
  always_comb begin
    prod_neg = '0 - acc_nxt;
    quot     = acc_nxt[WIDTH-1:0];
    rem      = acc_nxt[2*WIDTH-1:WIDTH];
    case (op_q)
      MD_MUL:                     fix_res = neg_q ? prod_neg[WIDTH-1:0] : quot;
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = neg_q ? prod_neg[2*WIDTH-1:WIDTH] : rem;
      MD_DIV, MD_DIVU:            fix_res = (neg_q && !dz_q) ? -quot : quot;
      default:                    fix_res = neg_q ? -rem : rem;
    endcase
  end

`ifdef MULDIV_FAST_PATH_EN
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  logic             fast;
  logic [WIDTH-1:0] fast_res;

  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
    if (!is_div(op)) begin
      fast     = (A == '0) || (B == '0);
      fast_res = '0;
    end else if (B == '0) begin
      fast     = 1'b1;
      fast_res = ((op == MD_DIV) || (op == MD_DIVU)) ? '1 : A;
    end else if (is_signed_a(op) && (A == MIN_VAL) && (B == '1)) begin
      fast     = 1'b1;
      fast_res = (op == MD_DIV) ? MIN_VAL : '0;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    dvs_d   = dvs_q;
    acc_d   = acc_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = op;
          neg_d = neg_in;
          dz_d  = (B == '0);
          cnt_d = '0;
          if (is_div(op)) begin
            acc_d = {{WIDTH{1'b0}}, mag_a};
            dvs_d = mag_b;
          end else begin
            acc_d = {{WIDTH{1'b0}}, mag_b};
            dvs_d = mag_a;
          end
          state_d = BUSY;
`ifdef MULDIV_FAST_PATH_EN
          if (fast) begin
            res_d   = fast_res;
            state_d = DONE;
          end
`endif
        end
      end
      BUSY: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_WIDTH'(WIDTH - 1)) begin
          res_d   = fix_res;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= MD_MUL;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      dvs_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
      dvs_q   <= dvs_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign Result    = res_q;

endmodule
